// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the async_fifo read-side stream consumer.
package fifo_rd_pkg;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} rd_state_t;

  localparam int unsigned OUT_DEPTH_DEF = 4;

  // Width needed to hold a count in 0..depth (never narrower than one bit).
  function automatic int unsigned occ_width(input int unsigned depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Small synchronous output buffer: tail push, head pop, occupancy count.
module fifo_rd_obuf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = OUT_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          push,
  input  logic [DATA_SIZE-1:0]          push_data,
  input  logic                          pop,
  output logic [occ_width(DEPTH)-1:0]   occ,
  output logic [DATA_SIZE-1:0]          head_data
);

  localparam int unsigned OCC_W = occ_width(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop  = pop && (occ != '0);
    do_push = push && (do_pop || (occ != OCC_W'(DEPTH)));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      assert (!(push && !do_pop && (occ == OCC_W'(DEPTH))));
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is zeroed only on reset so the head reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clr) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains async_fifo into a credit-controlled valid/ready stream with flush and beat count.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_empty,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_en,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 flush,
  output logic                 busy_flush,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam int unsigned OCC_W = occ_width(OUT_DEPTH);
  localparam int unsigned IF_W  = occ_width(READ_LAT);
  localparam int unsigned TAG_W = (READ_LAT > 0) ? READ_LAT : 1;

  rd_state_t        state;
  logic [OCC_W-1:0] occ;
  logic [IF_W-1:0]  inflight;
  logic [TAG_W-1:0] tag;
  logic             ret_valid;
  logic             credit_ok;
  logic             flush_go;
  logic             push;
  logic             pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LAT; i++) inflight = inflight + IF_W'(tag[i]);
  end

  // Credit uses registered occupancy only; a same-cycle downstream pop is not counted.
  always_comb begin
    credit_ok = (32'(occ) + 32'(inflight)) < OUT_DEPTH;
    r_en      = !r_rst && !r_empty && ((state == FLUSH) || credit_ok);
    m_valid   = (occ != '0) && (state == RUN);
    pop       = m_valid && m_ready;
    flush_go  = flush && (state == RUN);
    push      = ret_valid && (state == RUN) && !flush_go;
  end

  generate
    if (READ_LAT == 0) begin : g_lat0
      assign ret_valid = r_en;
      assign tag       = '0;
    end else begin : g_lat
      always_ff @(posedge r_clk) begin
        if (r_rst) begin
          tag <= '0;
        end else begin
          tag[0] <= r_en;
          for (int unsigned i = 1; i < READ_LAT; i++) tag[i] <= tag[i-1];
        end
      end
      assign ret_valid = tag[READ_LAT-1];
    end
  endgenerate

  fifo_rd_obuf #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (OUT_DEPTH)
  ) u_obuf (
    .clk       (r_clk),
    .rst       (r_rst),
    .clr       (flush_go),
    .push      (push),
    .push_data (r_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state      <= RUN;
      busy_flush <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (pop) beat_cnt <= beat_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (flush) begin
            state      <= FLUSH;
            busy_flush <= 1'b1;
          end
        end
        FLUSH: begin
          if (r_empty && (inflight == '0)) begin
            state      <= RUN;
            busy_flush <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          busy_flush <= 1'b0;
        end
      endcase
    end
  end

endmodule
